aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Sequencer for the shared iterative AES datapath: one round unit plus a word-serial key-expansion unit, used for AES-128/192/256, encrypt and decrypt.
- Accepts a job over a valid/ready handshake and, when a new key is supplied, runs key expansion one word per cycle.
- Drives round-key index, first/final-round strobes and datapath enables, then presents completion over a valid/ready handshake.
- Sits between the system request interface and the round/key-schedule datapath; owns no data, only control.

Parameters:
- RK_IDX_W, 4, width of round-key index (max Nr = 14).
- WORD_IDX_W, 6, width of key-schedule word index (max 59).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  reset, synchronous, active-high.
- in_valid  input  1  job request.
- in_ready  output  1  controller can accept a job.
- in_key_len  input  2  0=128, 1=192, 2=256, 3=reserved.
- in_new_key  input  1  key bus carries a new key; expand before use.
- in_decrypt  input  1  1=decrypt, 0=encrypt.
- out_valid  output  1  job complete (result or error).
- out_ready  input  1  consumer accepts completion.
- out_err  output  1  qualifies out_valid; job rejected.
- busy  output  1  state != IDLE.
- ks_load  output  1  capture key words 0..Nk-1 from key bus.
- ks_en  output  1  compute and store word ks_word_idx.
- ks_word_idx  output  WORD_IDX_W  schedule word being generated.
- ks_rot_sub  output  1  (i mod Nk)==0: RotWord+SubWord+Rcon.
- ks_sub_only  output  1  Nk==8 and (i mod 8)==4: SubWord only.
- ks_rcon_idx  output  4  i/Nk, Rcon selector, 1-based.
- dp_load  output  1  load plaintext/ciphertext and add round key rk_idx.
- dp_round_en  output  1  execute one round with key rk_idx.
- dp_final  output  1  final round; omit (Inv)MixColumns.
- dp_decrypt  output  1  registered in_decrypt of the current job.
- rk_idx  output  RK_IDX_W  round-key index (words 4*rk_idx..+3).

Behaviour:
- Nk/Nr: 128 gives 4/10, 192 gives 6/12, 256 gives 8/14. Key-expansion word count W = 4*(Nr+1) = 44/52/60.
- Reset values: every output 0 except in_ready=1. State IDLE. key_valid=0.
- States: IDLE, KEXP, LOAD, ROUND, FINAL, DONE. in_ready=1 only in IDLE. Accept = in_valid & in_ready.
- On accept: latch key_len, decrypt, new_key.
  - key_len==3 -> DONE with err.
  - new_key=0 and (key_valid=0 or latched len != stored len) -> DONE with err.
  - new_key=1 -> ks_load=1 in the accept cycle; next state KEXP; key_valid cleared.
  - otherwise -> LOAD.
- KEXP: ks_en=1 each cycle, i runs Nk..W-1, one word per cycle. That is 40/46/52 cycles for 128/192/256. Mod-Nk counter and Rcon counter are incremental; no divider.
- KEXP exit: after i=W-1, set key_valid=1, store key_len, go to LOAD.
- LOAD (1 cycle): dp_load=1, dp_round_en=0. rk_idx=0 for encrypt, Nr for decrypt.
- ROUND (Nr-1 cycles): dp_round_en=1. rk_idx counts 1..Nr-1 for encrypt, Nr-1..1 for decrypt.
- FINAL (1 cycle): dp_round_en=1, dp_final=1, rk_idx=Nr (enc) or 0 (dec). Go to DONE.
- DONE: out_valid=1, out_err as determined. Hold until out_ready, then go to IDLE.
  - in_ready stays 0 during DONE, so no new accept in the same cycle as the completion handshake.
- Latency with no KEXP: accept at T -> LOAD at T+1 -> out_valid at T+Nr+2 (T+12 / T+14 / T+16). KEXP adds W-Nk cycles. Error job: out_valid at T+1.
- dp_*, ks_* and rk_idx outputs are decoded from registered state/counters only, with no combinational path from in_* except ks_load.
- Reset mid-operation: next cycle IDLE, all outputs at reset values, key_valid=0. A partial key schedule is never considered valid.
- out_ready while out_valid=0 has no effect.

Decomposition:
- Package aes_pkg: key_len_e enum; ctrl_state_e enum; constants NK_128/192/256, NR_128/192/256; functions nk_of(key_len) and nr_of(key_len).
- Sub-module aes_ks_seq holds the key-expansion counters. It takes start and key_len, and returns ks_en, ks_word_idx, ks_rot_sub, ks_sub_only, ks_rcon_idx and done. aes_round_ctrl instantiates it.

Test Plan:
- 128 encrypt, new_key=1, out_ready=1 -> 40 ks_en cycles with idx 4..43 and ks_rot_sub at 4,8,...,40 (rcon 1..10). Then dp_load with rk_idx=0, rk_idx 1..9 in ROUND, dp_final with rk_idx=10. out_valid 52 cycles after accept, out_err=0.
- 192 then 256 encrypt, new_key=1 -> 192: ks_rot_sub at i=6,12,...,48, no ks_sub_only, 46 KEXP cycles. 256: ks_rot_sub at 8,...,56, ks_sub_only at 12,20,...,52, 52 KEXP cycles.
- 256 decrypt, new_key=0 after prior 256 expansion -> rk_idx 14,13..1,0 with dp_final at 0, out_valid at T+16.
- Errors:
  - key_len=3 -> out_valid=1, out_err=1 at T+1, no ks_en/dp_*.
  - new_key=0 right after reset -> out_err=1.
  - new_key=0 with len 192 after a 128 expansion -> out_err=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, in_ready stays 0, no dp activity. Release -> IDLE, in_ready=1 next cycle.
- Assert reset at KEXP word 20 -> all outputs 0, in_ready=1 next cycle. A following new_key=0 job -> out_err=1.

Source files
------------

// File: rtl/aes_round_ctrl_pkg.sv
// aes_pkg: shared types and key-size constants for the AES round controller.
// Holds the key-length and controller-state enums, the Nk/Nr/W constants
// for the three key sizes, and lookup helpers nk_of/nr_of/w_of.
package aes_pkg;

    typedef enum logic [1:0] {
        KEY_128  = 2'd0,
        KEY_192  = 2'd1,
        KEY_256  = 2'd2,
        KEY_RSVD = 2'd3
    } key_len_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEXP  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ROUND = 3'd3,
        ST_FINAL = 3'd4,
        ST_DONE  = 3'd5
    } ctrl_state_e;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    function automatic logic [3:0] nk_of(key_len_e key_len);
        case (key_len)
            KEY_192: return NK_192;
            KEY_256: return NK_256;
            default: return NK_128;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(key_len_e key_len);
        case (key_len)
            KEY_192: return NR_192;
            KEY_256: return NR_256;
            default: return NR_128;
        endcase
    endfunction

    // Total schedule words, 4*(Nr+1).
    function automatic logic [5:0] w_of(key_len_e key_len);
        case (key_len)
            KEY_192: return 6'd52;
            KEY_256: return 6'd60;
            default: return 6'd44;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: job request and completion handshakes.
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1; valid, once raised, holds its payload
// until that edge. Request: in_valid/in_ready with in_key_len, in_new_key,
// in_decrypt. Completion: out_valid/out_ready with out_err.
// master = requester/consumer side, slave = controller side.
interface aes_round_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_key_len;
    logic       in_new_key;
    logic       in_decrypt;
    logic       out_valid;
    logic       out_ready;
    logic       out_err;

    modport master (
        output in_valid, in_key_len, in_new_key, in_decrypt, out_ready,
        input  in_ready, out_valid, out_err
    );

    modport slave (
        input  in_valid, in_key_len, in_new_key, in_decrypt, out_ready,
        output in_ready, out_valid, out_err
    );
endinterface

// File: rtl/aes_round_ctrl_ks_seq.sv
// aes_ks_seq: word-serial key-expansion sequencer.
// Ports: clk, reset (sync, active-high); start pulses with key_len to begin
// expansion. Outputs ks_en, ks_word_idx (Nk..W-1), ks_rot_sub, ks_sub_only,
// ks_rcon_idx (i/Nk) per word, and done during the last word (i = W-1).
// i mod Nk and i/Nk are tracked with a wrapping counter and a counter that
// steps on each wrap, so no divider is needed.
module aes_ks_seq
    import aes_pkg::*;
#(
    parameter int WORD_IDX_W = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  key_len_e              key_len,
    output logic                  ks_en,
    output logic [WORD_IDX_W-1:0] ks_word_idx,
    output logic                  ks_rot_sub,
    output logic                  ks_sub_only,
    output logic [3:0]            ks_rcon_idx,
    output logic                  done
);

    logic                  en_q;
    logic [WORD_IDX_W-1:0] idx_q;
    logic [WORD_IDX_W-1:0] last_q;
    logic [3:0]            mod_q;
    logic [3:0]            rcon_q;
    logic [3:0]            nk_q;
    logic                  mod_wrap;

    assign mod_wrap = (mod_q == nk_q - 4'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q   <= 1'b0;
            idx_q  <= '0;
            last_q <= '0;
            mod_q  <= '0;
            rcon_q <= '0;
            nk_q   <= '0;
        end else if (start) begin
            // First generated word is i = Nk: mod 0, Rcon index 1.
            en_q   <= 1'b1;
            idx_q  <= WORD_IDX_W'(nk_of(key_len));
            last_q <= WORD_IDX_W'(w_of(key_len) - 6'd1);
            mod_q  <= '0;
            rcon_q <= 4'd1;
            nk_q   <= nk_of(key_len);
        end else if (en_q) begin
            if (idx_q == last_q) begin
                en_q <= 1'b0;
            end else begin
                idx_q  <= idx_q + WORD_IDX_W'(1);
                mod_q  <= mod_wrap ? 4'd0 : mod_q + 4'd1;
                rcon_q <= mod_wrap ? rcon_q + 4'd1 : rcon_q;
            end
        end
    end

    assign ks_en       = en_q;
    assign ks_word_idx = en_q ? idx_q : '0;
    assign ks_rot_sub  = en_q && (mod_q == 4'd0);
    assign ks_sub_only = en_q && (nk_q == NK_256) && (mod_q == 4'd4);
    assign ks_rcon_idx = en_q ? rcon_q : 4'd0;
    assign done        = en_q && (idx_q == last_q);

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: control sequencer for the iterative AES round/key datapath.
// Ports: clk, reset (sync, active-high); io (slave) carries the job request
// and completion handshakes; busy; ks_* drive the key-expansion unit;
// dp_* and rk_idx drive the round unit; dbg_state exposes the FSM state.
// All outputs are registered or decoded from registers, except ks_load,
// which fires in the accept cycle so the key bus is captured immediately.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int RK_IDX_W   = 4,
    parameter int WORD_IDX_W = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    aes_round_ctrl_if.slave       io,
    output logic                  busy,
    output logic                  ks_load,
    output logic                  ks_en,
    output logic [WORD_IDX_W-1:0] ks_word_idx,
    output logic                  ks_rot_sub,
    output logic                  ks_sub_only,
    output logic [3:0]            ks_rcon_idx,
    output logic                  dp_load,
    output logic                  dp_round_en,
    output logic                  dp_final,
    output logic                  dp_decrypt,
    output logic [RK_IDX_W-1:0]   rk_idx,
    output ctrl_state_e           dbg_state
);

    ctrl_state_e         state_q;
    logic                in_ready_q, busy_q, out_valid_q, out_err_q;
    logic                dp_load_q, dp_round_en_q, dp_final_q;
    logic [RK_IDX_W-1:0] rk_q;
    key_len_e            job_len_q, stored_len_q;
    logic                job_dec_q, key_valid_q;

    key_len_e            req_len;
    logic                req_err, ks_done;
    logic [RK_IDX_W-1:0] nr_req, nr_job;

    assign req_len = key_len_e'(io.in_key_len);
    assign nr_req  = RK_IDX_W'(nr_of(req_len));
    assign nr_job  = RK_IDX_W'(nr_of(job_len_q));

    // Reject reserved sizes, and key reuse when no complete schedule of the
    // same size is held.
    assign req_err = (req_len == KEY_RSVD) ||
                     (!io.in_new_key && (!key_valid_q || req_len != stored_len_q));

    assign ks_load = io.in_valid && in_ready_q && io.in_new_key && (req_len != KEY_RSVD);

    aes_ks_seq #(.WORD_IDX_W(WORD_IDX_W)) u_ks_seq (
        .clk         (clk),
        .reset       (reset),
        .start       (ks_load),
        .key_len     (req_len),
        .ks_en       (ks_en),
        .ks_word_idx (ks_word_idx),
        .ks_rot_sub  (ks_rot_sub),
        .ks_sub_only (ks_sub_only),
        .ks_rcon_idx (ks_rcon_idx),
        .done        (ks_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_err_q     <= 1'b0;
            dp_load_q     <= 1'b0;
            dp_round_en_q <= 1'b0;
            dp_final_q    <= 1'b0;
            rk_q          <= '0;
            job_len_q     <= KEY_128;
            job_dec_q     <= 1'b0;
            key_valid_q   <= 1'b0;
            stored_len_q  <= KEY_128;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (io.in_valid) begin
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        job_len_q  <= req_len;
                        job_dec_q  <= io.in_decrypt;
                        if (req_err) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            out_err_q   <= 1'b1;
                        end else if (io.in_new_key) begin
                            // Old schedule is being overwritten from now on.
                            state_q     <= ST_KEXP;
                            key_valid_q <= 1'b0;
                        end else begin
                            state_q   <= ST_LOAD;
                            dp_load_q <= 1'b1;
                            rk_q      <= io.in_decrypt ? nr_req : '0;
                        end
                    end
                end
                ST_KEXP: begin
                    if (ks_done) begin
                        key_valid_q  <= 1'b1;
                        stored_len_q <= job_len_q;
                        state_q      <= ST_LOAD;
                        dp_load_q    <= 1'b1;
                        rk_q         <= job_dec_q ? nr_job : '0;
                    end
                end
                ST_LOAD: begin
                    state_q       <= ST_ROUND;
                    dp_load_q     <= 1'b0;
                    dp_round_en_q <= 1'b1;
                    rk_q          <= job_dec_q ? nr_job - RK_IDX_W'(1) : RK_IDX_W'(1);
                end
                ST_ROUND: begin
                    if (job_dec_q ? (rk_q == RK_IDX_W'(1)) : (rk_q == nr_job - RK_IDX_W'(1))) begin
                        state_q    <= ST_FINAL;
                        dp_final_q <= 1'b1;
                        rk_q       <= job_dec_q ? '0 : nr_job;
                    end else begin
                        rk_q <= job_dec_q ? rk_q - RK_IDX_W'(1) : rk_q + RK_IDX_W'(1);
                    end
                end
                ST_FINAL: begin
                    state_q       <= ST_DONE;
                    dp_round_en_q <= 1'b0;
                    dp_final_q    <= 1'b0;
                    rk_q          <= '0;
                    out_valid_q   <= 1'b1;
                    out_err_q     <= 1'b0;
                end
                ST_DONE: begin
                    if (io.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        out_err_q   <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_err   = out_err_q;
    assign busy         = busy_q;
    assign dp_load      = dp_load_q;
    assign dp_round_en  = dp_round_en_q;
    assign dp_final     = dp_final_q;
    assign dp_decrypt   = job_dec_q;
    assign rk_idx       = rk_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: self-checking bench for aes_round_ctrl.
// A reference model derives, from the AES key-size rules, the expected
// key-schedule word list, round-key sequence, latency and error outcome of
// each job; scenario tasks compare the DUT against it.
module tb_aes_round_ctrl;
    import aes_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy, ks_load, ks_en, ks_rot_sub, ks_sub_only;
    logic [5:0]  ks_word_idx;
    logic [3:0]  ks_rcon_idx;
    logic        dp_load, dp_round_en, dp_final, dp_decrypt;
    logic [3:0]  rk_idx;
    ctrl_state_e dbg_state;

    int checks = 0;
    int failures = 0;

    // Model of the key store: a schedule is usable only after a full expansion.
    bit m_kv = 1'b0;
    int m_len = 0;

    aes_round_ctrl_if io ();

    always #5 clk = ~clk;

    aes_round_ctrl #(.RK_IDX_W(4), .WORD_IDX_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .io          (io),
        .busy        (busy),
        .ks_load     (ks_load),
        .ks_en       (ks_en),
        .ks_word_idx (ks_word_idx),
        .ks_rot_sub  (ks_rot_sub),
        .ks_sub_only (ks_sub_only),
        .ks_rcon_idx (ks_rcon_idx),
        .dp_load     (dp_load),
        .dp_round_en (dp_round_en),
        .dp_final    (dp_final),
        .dp_decrypt  (dp_decrypt),
        .rk_idx      (rk_idx),
        .dbg_state   (dbg_state)
    );

    function automatic int nk_m(int len);
        return (len == 0) ? 4 : (len == 1) ? 6 : 8;
    endfunction

    function automatic int nr_m(int len);
        return (len == 0) ? 10 : (len == 1) ? 12 : 14;
    endfunction

    // Every output except in_ready, which must all be zero at reset.
    function automatic logic [24:0] outs_vec();
        return {io.out_valid, io.out_err, busy, ks_load, ks_en, ks_word_idx,
                ks_rot_sub, ks_sub_only, ks_rcon_idx, dp_load, dp_round_en,
                dp_final, dp_decrypt, rk_idx};
    endfunction

    task automatic do_reset();
        io.in_valid = 1'b0; io.in_key_len = 2'd0; io.in_new_key = 1'b0;
        io.in_decrypt = 1'b0; io.out_ready = 1'b0;
        @(negedge clk); reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_kv = 1'b0;
    endtask

    // Drives one job and monitors it to completion. Expected traces come from
    // the model; every per-cycle disagreement increments bad.
    task automatic run_job(input int len, input bit nk, input bit dec, input int hold,
                           output int lat, output int exp_lat, output bit err,
                           output bit exp_err, output int bad, output int ks_cnt,
                           output int dp_cnt, output bit ready_after);
        logic [11:0] ks_q[$];
        logic [6:0]  exp_q[$];
        logic [11:0] kv;
        logic [6:0]  dv;
        int nkw, nr, w;
        nkw = nk_m(len); nr = nr_m(len); w = 4 * (nr + 1);
        exp_err = (len == 3) || (!nk && (!m_kv || len != m_len));
        exp_lat = exp_err ? 1 : ((nk ? (w - nkw) : 0) + nr + 2);
        if (!exp_err) begin
            if (nk) begin
                for (int i = nkw; i < w; i++) begin
                    kv = '0;
                    kv[11:6] = 6'(i);
                    kv[5] = (i % nkw == 0);
                    kv[4] = (nkw == 8) && (i % nkw == 4);
                    kv[3:0] = 4'(i / nkw);
                    ks_q.push_back(kv);
                end
            end
            exp_q.push_back({3'b100, 4'(dec ? nr : 0)});
            for (int r = 1; r < nr; r++) exp_q.push_back({3'b010, 4'(dec ? nr - r : r)});
            exp_q.push_back({3'b011, 4'(dec ? 0 : nr)});
        end
        bad = 0; ks_cnt = 0; dp_cnt = 0; lat = -1; err = 1'b0;
        @(negedge clk);
        if (io.in_ready !== 1'b1) bad++;
        io.in_valid = 1'b1; io.in_key_len = 2'(len); io.in_new_key = nk;
        io.in_decrypt = dec; io.out_ready = (hold == 0);
        #1;
        if (ks_load !== (nk && len != 3)) bad++;
        @(posedge clk);
        #1;
        // Scramble request lines: the job must run from its latched values.
        io.in_valid = 1'b0; io.in_key_len = 2'($urandom_range(0, 3));
        io.in_new_key = 1'($urandom_range(0, 1)); io.in_decrypt = 1'($urandom_range(0, 1));
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (io.out_valid === 1'b1) begin lat = c; break; end
            if (io.in_ready !== 1'b0 || busy !== 1'b1 || ks_load !== 1'b0) bad++;
            if (ks_en === 1'b1) begin
                ks_cnt++;
                if (ks_q.size() == 0) bad++;
                else begin
                    kv = ks_q.pop_front();
                    if ({ks_word_idx, ks_rot_sub, ks_sub_only, ks_rcon_idx} !== kv) begin
                        bad++;
                        $display("note: ks word obs=%h exp=%h", {ks_word_idx, ks_rot_sub, ks_sub_only, ks_rcon_idx}, kv);
                    end
                end
            end
            if (dp_load === 1'b1 || dp_round_en === 1'b1 || dp_final === 1'b1) begin
                dp_cnt++;
                if (dp_decrypt !== dec) bad++;
                if (exp_q.size() == 0) bad++;
                else begin
                    dv = exp_q.pop_front();
                    if ({dp_load, dp_round_en, dp_final, rk_idx} !== dv) begin
                        bad++;
                        $display("note: dp step obs=%h exp=%h", {dp_load, dp_round_en, dp_final, rk_idx}, dv);
                    end
                end
            end
        end
        bad += ks_q.size() + exp_q.size();
        if (lat >= 0) begin
            err = io.out_err;
            for (int h = 0; h <= hold; h++) begin
                if (h > 0) @(negedge clk);
                if (io.out_valid !== 1'b1 || io.out_err !== err || io.in_ready !== 1'b0 ||
                    ks_en !== 1'b0 || dp_load !== 1'b0 || dp_round_en !== 1'b0 || dp_final !== 1'b0)
                    bad++;
            end
            io.out_ready = 1'b1;
            @(negedge clk);
            ready_after = (io.in_ready === 1'b1) && (io.out_valid === 1'b0) && (busy === 1'b0);
        end else begin
            ready_after = 1'b0;
        end
        io.out_ready = 1'b0;
        if (!exp_err && nk) begin m_kv = 1'b1; m_len = len; end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (io.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready obs=%b exp=1", io.in_ready);
        end
        checks++;
        if (outs_vec() !== 25'd0) begin
            failures++; $display("FAIL reset_outputs obs=%h exp=0", outs_vec());
        end
    endtask

    task automatic test_enc(input int len, input int exp_ks, input int exp_total);
        int lat, elat, bad, kc, dc; bit err, eerr, rdy;
        run_job(len, 1'b1, 1'b0, 0, lat, elat, err, eerr, bad, kc, dc, rdy);
        checks++;
        if (lat !== exp_total || lat !== elat) begin
            failures++; $display("FAIL enc%0d_latency obs=%0d exp=%0d", len, lat, exp_total);
        end
        checks++;
        if (kc !== exp_ks) begin
            failures++; $display("FAIL enc%0d_ks_cycles obs=%0d exp=%0d", len, kc, exp_ks);
        end
        checks++;
        if (bad !== 0 || err !== 1'b0 || dc !== nr_m(len) + 1) begin
            failures++; $display("FAIL enc%0d_trace bad=%0d err=%b dp=%0d exp bad=0 err=0 dp=%0d", len, bad, err, dc, nr_m(len) + 1);
        end
        checks++;
        if (rdy !== 1'b1) begin
            failures++; $display("FAIL enc%0d_ready_after obs=%b exp=1", len, rdy);
        end
    endtask

    task automatic test_dec256_reuse();
        int lat, elat, bad, kc, dc; bit err, eerr, rdy;
        run_job(2, 1'b0, 1'b1, 0, lat, elat, err, eerr, bad, kc, dc, rdy);
        checks++;
        if (lat !== 16 || err !== 1'b0) begin
            failures++; $display("FAIL dec256_latency obs=%0d err=%b exp=16 err=0", lat, err);
        end
        checks++;
        if (bad !== 0 || kc !== 0 || dc !== 15) begin
            failures++; $display("FAIL dec256_trace bad=%0d ks=%0d dp=%0d exp 0/0/15", bad, kc, dc);
        end
    endtask

    task automatic test_errors();
        int lat, elat, bad, kc, dc; bit err, eerr, rdy;
        do_reset();
        run_job(0, 1'b0, 1'b0, 0, lat, elat, err, eerr, bad, kc, dc, rdy);
        checks++;
        if (err !== 1'b1 || lat !== 1 || bad !== 0 || rdy !== 1'b1) begin
            failures++; $display("FAIL err_no_key err=%b lat=%0d bad=%0d exp err=1 lat=1 bad=0", err, lat, bad);
        end
        run_job(3, 1'b1, 1'b0, 0, lat, elat, err, eerr, bad, kc, dc, rdy);
        checks++;
        if (err !== 1'b1 || lat !== 1 || kc !== 0 || dc !== 0 || bad !== 0) begin
            failures++; $display("FAIL err_reserved err=%b lat=%0d ks=%0d dp=%0d exp 1/1/0/0", err, lat, kc, dc);
        end
        run_job(0, 1'b1, 1'b0, 0, lat, elat, err, eerr, bad, kc, dc, rdy);
        run_job(1, 1'b0, 1'b0, 0, lat, elat, err, eerr, bad, kc, dc, rdy);
        checks++;
        if (err !== 1'b1 || lat !== 1 || dc !== 0) begin
            failures++; $display("FAIL err_len_change err=%b lat=%0d dp=%0d exp 1/1/0", err, lat, dc);
        end
    endtask

    task automatic test_backpressure();
        int lat, elat, bad, kc, dc; bit err, eerr, rdy;
        run_job(0, 1'b0, 1'b0, 5, lat, elat, err, eerr, bad, kc, dc, rdy);
        checks++;
        if (bad !== 0 || err !== 1'b0 || lat !== 12) begin
            failures++; $display("FAIL backpressure_hold bad=%0d err=%b lat=%0d exp 0/0/12", bad, err, lat);
        end
        checks++;
        if (rdy !== 1'b1) begin
            failures++; $display("FAIL backpressure_release obs=%b exp=1", rdy);
        end
    endtask

    task automatic test_reset_mid_kexp();
        int lat, elat, bad, kc, dc; bit err, eerr, rdy;
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        io.in_valid = 1'b1; io.in_key_len = 2'd0; io.in_new_key = 1'b1; io.in_decrypt = 1'b0;
        @(posedge clk); #1 io.in_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ks_en === 1'b1 && ks_word_idx === 6'd20) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL kexp_word20_reached obs=0 exp=1");
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_kv = 1'b0;
        checks++;
        if (outs_vec() !== 25'd0 || io.in_ready !== 1'b1) begin
            failures++; $display("FAIL mid_reset_outputs obs=%h in_ready=%b exp=0 in_ready=1", outs_vec(), io.in_ready);
        end
        run_job(0, 1'b0, 1'b0, 0, lat, elat, err, eerr, bad, kc, dc, rdy);
        checks++;
        if (err !== 1'b1 || lat !== 1) begin
            failures++; $display("FAIL mid_reset_key_invalid err=%b lat=%0d exp err=1 lat=1", err, lat);
        end
    endtask

    task automatic test_random();
        int lat, elat, bad, kc, dc; bit err, eerr, rdy;
        int len, hold; bit nk, dec;
        for (int j = 0; j < 14; j++) begin
            len = $urandom_range(0, 3);
            nk = ($urandom_range(0, 2) != 0);
            dec = 1'($urandom_range(0, 1));
            hold = $urandom_range(0, 3);
            run_job(len, nk, dec, hold, lat, elat, err, eerr, bad, kc, dc, rdy);
            checks++;
            if (lat !== elat || err !== eerr || bad !== 0 || rdy !== 1'b1) begin
                failures++;
                $display("FAIL random_job%0d len=%0d nk=%b dec=%b lat=%0d/%0d err=%b/%b bad=%0d rdy=%b",
                         j, len, nk, dec, lat, elat, err, eerr, bad, rdy);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_enc(0, 40, 52);
        test_enc(1, 46, 60);
        test_enc(2, 52, 68);
        test_dec256_reuse();
        test_errors();
        test_backpressure();
        test_reset_mid_kexp();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
